ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the RV32I pipeline; sits directly upstream of the memory stage and drives its `*_EM` inputs.
- Computes ALU results and load/store addresses, replicates store data to the access size, and flags misaligned accesses.
- Contains an optional iterative RV32M multiply/divide unit. While that unit is busy it stalls decode and emits bubbles.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.
- MD_ITER, 32, number of multiply/divide iterations, one result bit per cycle.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  reset, synchronous, active-high.
- VALID_DE  input  1  decode presents a valid instruction.
- ALU_OP_DE  input  5  operation code (encoding below).
- SRC1_DE  input  32  operand A (rs1 or PC).
- SRC2_DE  input  32  operand B (rs2 or immediate, already muxed).
- STORE_DATA_DE  input  32  rs2 value used for stores.
- RD_DE  input  5  destination register.
- RegWrite_DE  input  1  instruction writes rd.
- MemWrite_DE  input  2  store size: 00 none, 01 byte, 10 half, 11 word.
- MemRead_DE  input  2  load size, same encoding as MemWrite_DE.
- LoadUnsigned_DE  input  1  load is zero-extended (LBU/LHU).
- STALL_E  output  1  combinational; decode must hold all `_DE` inputs while high.
- VALID_EM  output  1  EM register holds a valid instruction.
- WA_EM  output  32  ALU result, or the memory address for loads/stores.
- WD_EM  output  32  store data, replicated to the access size.
- MemWrite_EM  output  2  store size.
- MemRead_EM  output  2  load size.
- LoadUnsigned_EM  output  1  pass-through of LoadUnsigned_DE.
- RD_EM  output  5  destination register.
- RegWrite_EM  output  1  write-enable for rd.
- MISALIGN_EM  output  1  misaligned access detected.

Behaviour:
- Reset: synchronous and active-high. Every EM output resets to 0, the FSM goes to IDLE, and the iteration counter clears. Asserting RST mid-multiply/divide aborts the operation; if decode still presents it afterwards, it restarts from IDLE.
- Opcodes: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB (result = SRC2). 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU. Any other code: result 0, RegWrite_EM forced 0.
- Shifts use SRC2[4:0]. SLT is signed; SLTU is unsigned.
- ALU ops: single-cycle. The EM registers update at the first edge with VALID_DE=1 and STALL_E=0.
- VALID_DE=0: a bubble enters EM. VALID_EM=0 and all write/read controls are 0.
- Store data replication on WD_EM:
  - byte: {4{STORE_DATA[7:0]}}
  - half: {2{STORE_DATA[15:0]}}
  - word: STORE_DATA unchanged
- Misalignment: a half access with addr[0]=1, or a word access with addr[1:0]≠0, sets MISALIGN_EM=1 and forces MemWrite_EM=MemRead_EM=00 and RegWrite_EM=0.
- Multiply/divide FSM: IDLE → BUSY → DONE → IDLE.
  - STALL_E = VALID_DE & is_md & (state≠DONE).
  - IDLE: on a valid md op, latch the operand magnitudes and sign flags, clear the counter, go to BUSY.
  - BUSY: one shift-add (multiply) or shift-subtract (divide) step per cycle. After counter reaches MD_ITER-1, go to DONE.
  - DONE: apply the sign fix, load the result into EM, go to IDLE.
  - While STALL_E is high, EM receives bubbles.
  - Timing: the op is presented at cycle 0, STALL_E is high for 33 cycles, and the result appears on WA_EM after the edge ending cycle 33.
- Multiply/divide result rules:
  - MUL returns the low 32 bits of the product; MULH/MULHSU/MULHU return the high 32 bits with the respective signedness.
  - Divide by zero: quotient 0xFFFFFFFF, remainder = dividend.
  - Signed overflow (0x80000000 / -1): quotient 0x80000000, remainder 0.
  - Remainder sign follows the dividend.
- VALID_DE dropping while the FSM is BUSY is a protocol violation by decode; the FSM completes anyway.

Optional Feature:
- Macro: EX_MULDIV_EN.
- Defined: the multiply/divide FSM and opcodes 16–23 are supported as described above.
- Undefined: no FSM is built and STALL_E is tied to 0. Opcodes 16–23 retire in one cycle with WA_EM=0, RegWrite_EM=0 and VALID_EM=1.

Test Plan:
- Reset: hold RST high for 2 cycles → all EM outputs 0 and STALL_E=0.
- Signed vs unsigned compare: SLT with SRC1=0xFFFFFFFF, SRC2=1 → WA_EM=1 one cycle later; SLTU with the same operands → WA_EM=0.
- Store byte: MemWrite=01, SRC1+SRC2=0x103, STORE_DATA=0x12345678 → WA_EM=0x103, WD_EM=0x78787878, MISALIGN_EM=0.
- Misaligned word load: MemRead=11, address 0x102 → MISALIGN_EM=1, MemRead_EM=00, RegWrite_EM=0.
- DIV edge cases (EX_MULDIV_EN defined): 0x80000000 / 0xFFFFFFFF → STALL_E high for 33 cycles, then WA_EM=0x80000000. DIVU 7/0 → 0xFFFFFFFF. REM −7/2 → 0xFFFFFFFF.
- Reset mid-operation: assert RST at cycle 10 of a MULH −3×5 → outputs zero. Release RST with the op still presented → restart, then WA_EM=0xFFFFFFFF after 34 cycles.

Source files
------------

// File: rtl/ex_stage_if.sv
// ex_stage_if: decode-to-execute and execute-to-memory signal bundle.
// Handshake: decode offers an instruction with VALID_DE. STALL_E acts as an
// inverted ready, so an instruction transfers on a rising edge where
// VALID_DE=1 and STALL_E=0. While STALL_E is high, decode holds every _DE
// signal stable. The EM side has no back-pressure: VALID_EM qualifies the
// EM register contents on every cycle.
// md_state is a debug view of the multiply/divide FSM (0 when not built).
interface ex_stage_if;
    logic        VALID_DE;
    logic [4:0]  ALU_OP_DE;
    logic [31:0] SRC1_DE;
    logic [31:0] SRC2_DE;
    logic [31:0] STORE_DATA_DE;
    logic [4:0]  RD_DE;
    logic        RegWrite_DE;
    logic [1:0]  MemWrite_DE;
    logic [1:0]  MemRead_DE;
    logic        LoadUnsigned_DE;

    logic        STALL_E;
    logic        VALID_EM;
    logic [31:0] WA_EM;
    logic [31:0] WD_EM;
    logic [1:0]  MemWrite_EM;
    logic [1:0]  MemRead_EM;
    logic        LoadUnsigned_EM;
    logic [4:0]  RD_EM;
    logic        RegWrite_EM;
    logic        MISALIGN_EM;
    logic [1:0]  md_state;

    modport master (
        output VALID_DE, ALU_OP_DE, SRC1_DE, SRC2_DE, STORE_DATA_DE, RD_DE,
               RegWrite_DE, MemWrite_DE, MemRead_DE, LoadUnsigned_DE,
        input  STALL_E, VALID_EM, WA_EM, WD_EM, MemWrite_EM, MemRead_EM,
               LoadUnsigned_EM, RD_EM, RegWrite_EM, MISALIGN_EM, md_state
    );

    modport slave (
        input  VALID_DE, ALU_OP_DE, SRC1_DE, SRC2_DE, STORE_DATA_DE, RD_DE,
               RegWrite_DE, MemWrite_DE, MemRead_DE, LoadUnsigned_DE,
        output STALL_E, VALID_EM, WA_EM, WD_EM, MemWrite_EM, MemRead_EM,
               LoadUnsigned_EM, RD_EM, RegWrite_EM, MISALIGN_EM, md_state
    );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: RV32I execute stage. Single-cycle ALU, load/store address
// generation, store data replication and misalignment detection.
// Optional macro EX_MULDIV_EN builds an iterative RV32M multiply/divide
// unit (one result bit per cycle) that stalls decode while it works.
module ex_stage #(
    parameter int XLEN    = 32,
    parameter int MD_ITER = 32
) (
    input logic     CLK,
    input logic     RST,
    ex_stage_if.slave bus
);
    // Only a 32-bit datapath with one iteration per result bit is supported.
    if (XLEN != 32) begin : g_xlen_check
        $error("ex_stage: XLEN must be 32");
    end
    if (MD_ITER != XLEN) begin : g_iter_check
        $error("ex_stage: MD_ITER must equal XLEN");
    end

    localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_SLL = 5'd2, OP_SLT = 5'd3,
                           OP_SLTU = 5'd4, OP_XOR = 5'd5, OP_SRL = 5'd6, OP_SRA = 5'd7,
                           OP_OR = 5'd8, OP_AND = 5'd9, OP_PASSB = 5'd10;

    logic [4:0]      op;
    logic [XLEN-1:0] src1, src2, store_data;
    logic [4:0]      shamt;
    logic            is_md;

    assign op         = bus.ALU_OP_DE;
    assign src1       = bus.SRC1_DE;
    assign src2       = bus.SRC2_DE;
    assign store_data = bus.STORE_DATA_DE;
    assign shamt      = bus.SRC2_DE[4:0];
    assign is_md      = (op[4:3] == 2'b10);

    logic [XLEN-1:0] alu_res;
    logic            alu_known;

    // Single-cycle ALU; unknown codes (including md codes when no unit exists) give 0.
    always_comb begin
        alu_res   = '0;
        alu_known = 1'b1;
        case (op)
            OP_ADD:   alu_res = src1 + src2;
            OP_SUB:   alu_res = src1 - src2;
            OP_SLL:   alu_res = src1 << shamt;
            OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, ($signed(src1) < $signed(src2))};
            OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, (src1 < src2)};
            OP_XOR:   alu_res = src1 ^ src2;
            OP_SRL:   alu_res = src1 >> shamt;
            OP_SRA:   alu_res = $unsigned($signed(src1) >>> shamt);
            OP_OR:    alu_res = src1 | src2;
            OP_AND:   alu_res = src1 & src2;
            OP_PASSB: alu_res = src2;
            default:  alu_known = 1'b0;
        endcase
    end

    logic [1:0]      mem_size;
    logic [XLEN-1:0] mem_addr, ex_wa, ex_wd;
    logic            is_mem, misalign;

    // Address, alignment check and store data replication for the access size.
    always_comb begin
        mem_size = (bus.MemWrite_DE != 2'b00) ? bus.MemWrite_DE : bus.MemRead_DE;
        mem_addr = src1 + src2;
        is_mem   = (mem_size != 2'b00);
        misalign = ((mem_size == 2'b10) && mem_addr[0]) ||
                   ((mem_size == 2'b11) && (mem_addr[1:0] != 2'b00));
        ex_wa    = is_mem ? mem_addr : alu_res;
        case (bus.MemWrite_DE)
            2'b01:   ex_wd = {4{store_data[7:0]}};
            2'b10:   ex_wd = {2{store_data[15:0]}};
            default: ex_wd = store_data;
        endcase
    end

    logic            stall, md_done, md_busy, md_rw;
    logic [4:0]      md_rd;
    logic [XLEN-1:0] md_result;

`ifdef EX_MULDIV_EN
    localparam logic [1:0] S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2;
    localparam int CW = (MD_ITER > 1) ? $clog2(MD_ITER) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MD_ITER - 1);

    logic [1:0]      state;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] md_a, md_hi, md_lo;
    logic [2:0]      md_op;
    logic            md_neg_res, md_neg_rem, md_rw_q;
    logic [4:0]      md_rd_q;

    logic            a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;

    // Operand signedness and magnitudes: MUL/MULH/MULHSU/DIV/REM treat rs1 as signed.
    always_comb begin
        a_signed = (op[2:0] == 3'd0) || (op[2:0] == 3'd1) || (op[2:0] == 3'd2) ||
                   (op[2:0] == 3'd4) || (op[2:0] == 3'd6);
        b_signed = (op[2:0] == 3'd0) || (op[2:0] == 3'd1) ||
                   (op[2:0] == 3'd4) || (op[2:0] == 3'd6);
        a_neg    = a_signed && src1[XLEN-1];
        b_neg    = b_signed && src2[XLEN-1];
        a_mag    = a_neg ? (~src1 + 1'b1) : src1;
        b_mag    = b_neg ? (~src2 + 1'b1) : src2;
    end

    logic [XLEN:0]   mul_sum, div_rt, div_diff;
    logic            div_geq;
    logic [XLEN-1:0] step_hi, step_lo;

    // One iteration: shift-add for multiply, restoring shift-subtract for divide.
    always_comb begin
        mul_sum  = {1'b0, md_hi} + (md_lo[0] ? {1'b0, md_a} : '0);
        div_rt   = {md_hi, md_lo[XLEN-1]};
        div_diff = div_rt - {1'b0, md_a};
        div_geq  = (div_rt >= {1'b0, md_a});
        if (md_op[2]) begin
            step_hi = div_geq ? div_diff[XLEN-1:0] : div_rt[XLEN-1:0];
            step_lo = {md_lo[XLEN-2:0], div_geq};
        end else begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], md_lo[XLEN-1:1]};
        end
    end

    // IDLE -> BUSY -> DONE -> IDLE sequencing and the iteration datapath.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_IDLE;
            cnt        <= '0;
            md_a       <= '0;
            md_hi      <= '0;
            md_lo      <= '0;
            md_op      <= 3'd0;
            md_neg_res <= 1'b0;
            md_neg_rem <= 1'b0;
            md_rd_q    <= 5'd0;
            md_rw_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.VALID_DE && is_md) begin
                        state      <= S_BUSY;
                        cnt        <= '0;
                        md_op      <= op[2:0];
                        md_rd_q    <= bus.RD_DE;
                        md_rw_q    <= bus.RegWrite_DE;
                        md_hi      <= '0;
                        // A zero divisor keeps the all-ones quotient positive.
                        md_neg_res <= op[2] ? ((a_neg ^ b_neg) && (src2 != '0)) : (a_neg ^ b_neg);
                        md_neg_rem <= a_neg;
                        md_a       <= op[2] ? b_mag : a_mag;
                        md_lo      <= op[2] ? a_mag : b_mag;
                    end
                end
                S_BUSY: begin
                    md_hi <= step_hi;
                    md_lo <= step_lo;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CNT_LAST) state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    logic [2*XLEN-1:0] prod, prod_fix;

    // Sign fix and result selection once the iterations are finished.
    always_comb begin
        prod     = {md_hi, md_lo};
        prod_fix = md_neg_res ? (~prod + 1'b1) : prod;
        case (md_op)
            3'd0:       md_result = prod_fix[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:       md_result = prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5: md_result = md_neg_res ? (~md_lo + 1'b1) : md_lo;
            default:    md_result = md_neg_rem ? (~md_hi + 1'b1) : md_hi;
        endcase
    end

    assign stall        = bus.VALID_DE && is_md && (state != S_DONE);
    assign md_done      = (state == S_DONE);
    assign md_busy      = (state == S_BUSY);
    assign md_rd        = md_rd_q;
    assign md_rw        = md_rw_q;
    assign bus.md_state = state;
`else
    assign stall        = 1'b0;
    assign md_done      = 1'b0;
    assign md_busy      = 1'b0;
    assign md_rd        = 5'd0;
    assign md_rw        = 1'b0;
    assign md_result    = '0;
    assign bus.md_state = 2'b00;
`endif

    assign bus.STALL_E = stall;

    // EM pipeline register: md result, bubble, or the single-cycle instruction.
    always_ff @(posedge CLK) begin
        if (RST) begin
            bus.VALID_EM        <= 1'b0;
            bus.WA_EM           <= '0;
            bus.WD_EM           <= '0;
            bus.MemWrite_EM     <= 2'b00;
            bus.MemRead_EM      <= 2'b00;
            bus.LoadUnsigned_EM <= 1'b0;
            bus.RD_EM           <= 5'd0;
            bus.RegWrite_EM     <= 1'b0;
            bus.MISALIGN_EM     <= 1'b0;
        end else if (md_done) begin
            bus.VALID_EM        <= 1'b1;
            bus.WA_EM           <= md_result;
            bus.WD_EM           <= '0;
            bus.MemWrite_EM     <= 2'b00;
            bus.MemRead_EM      <= 2'b00;
            bus.LoadUnsigned_EM <= 1'b0;
            bus.RD_EM           <= md_rd;
            bus.RegWrite_EM     <= md_rw;
            bus.MISALIGN_EM     <= 1'b0;
        end else if (!bus.VALID_DE || stall || md_busy) begin
            bus.VALID_EM        <= 1'b0;
            bus.WA_EM           <= '0;
            bus.WD_EM           <= '0;
            bus.MemWrite_EM     <= 2'b00;
            bus.MemRead_EM      <= 2'b00;
            bus.LoadUnsigned_EM <= 1'b0;
            bus.RD_EM           <= 5'd0;
            bus.RegWrite_EM     <= 1'b0;
            bus.MISALIGN_EM     <= 1'b0;
        end else begin
            bus.VALID_EM        <= 1'b1;
            bus.WA_EM           <= ex_wa;
            bus.WD_EM           <= ex_wd;
            bus.MemWrite_EM     <= misalign ? 2'b00 : bus.MemWrite_DE;
            bus.MemRead_EM      <= misalign ? 2'b00 : bus.MemRead_DE;
            bus.LoadUnsigned_EM <= bus.LoadUnsigned_DE;
            bus.RD_EM           <= bus.RD_DE;
            bus.RegWrite_EM     <= bus.RegWrite_DE && alu_known && !misalign;
            bus.MISALIGN_EM     <= misalign;
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: self-checking bench for ex_stage with a behavioural model.
module tb_ex_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    ex_stage_if bus ();

    ex_stage dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] sd, input logic [4:0] rd, input logic rw,
                         input logic [1:0] mw, input logic [1:0] mr, input logic lu);
        bus.VALID_DE        = v;
        bus.ALU_OP_DE       = op;
        bus.SRC1_DE         = a;
        bus.SRC2_DE         = b;
        bus.STORE_DATA_DE   = sd;
        bus.RD_DE           = rd;
        bus.RegWrite_DE     = rw;
        bus.MemWrite_DE     = mw;
        bus.MemRead_DE      = mr;
        bus.LoadUnsigned_DE = lu;
    endtask

    function automatic logic [76:0] em_vec();
        return {bus.VALID_EM, bus.WA_EM, bus.WD_EM, bus.MemWrite_EM, bus.MemRead_EM,
                bus.LoadUnsigned_EM, bus.RD_EM, bus.RegWrite_EM, bus.MISALIGN_EM};
    endfunction

    // Reference ALU straight from the opcode table.
    function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        case (op)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return a << b[4:0];
            5'd3:  return (sa < sb) ? 32'd1 : 32'd0;
            5'd4:  return (a < b) ? 32'd1 : 32'd0;
            5'd5:  return a ^ b;
            5'd6:  return a >> b[4:0];
            5'd7:  return 32'(sa >>> b[4:0]);
            5'd8:  return a | b;
            5'd9:  return a & b;
            5'd10: return b;
            default: return 32'd0;
        endcase
    endfunction

    // Expected EM contents for a single-cycle instruction or bubble.
    function automatic logic [76:0] ref_em(input logic v, input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] sd, input logic [4:0] rd,
                                           input logic rw, input logic [1:0] mw, input logic [1:0] mr,
                                           input logic lu);
        logic [31:0] addr, wa, wd;
        logic [1:0]  size;
        logic        mis, known;
        if (!v) return '0;
        addr  = a + b;
        size  = (mw != 0) ? mw : mr;
        mis   = (size == 2 && addr % 2 != 0) || (size == 3 && addr % 4 != 0);
        wa    = (size != 0) ? addr : ref_alu(op, a, b);
        known = (op <= 10);
        if (mw == 1)      wd = {sd[7:0], sd[7:0], sd[7:0], sd[7:0]};
        else if (mw == 2) wd = {sd[15:0], sd[15:0]};
        else              wd = sd;
        return {1'b1, wa, wd, mis ? 2'b00 : mw, mis ? 2'b00 : mr, lu, rd, rw && known && !mis, mis};
    endfunction

    // Reference RV32M result using wide arithmetic and the RISC-V corner rules.
    function automatic logic [31:0] ref_md(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int sa, sb;
        sa = a;
        sb = b;
        case (op[2:0])
            3'd0: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[31:0]; end
            3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
            3'd2: begin p = {{32{a[31]}}, a} * {32'd0, b};       return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b};             return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 5'd0, 32'h1111_0000, 32'h0000_2222, 32'hDEAD_BEEF, 5'd9, 1'b1, 2'b00, 2'b00, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (em_vec() !== 77'd0) begin
            errors++;
            $display("FAIL reset_em: got %h want 0", em_vec());
        end
        checks++;
        if (bus.STALL_E !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall: got %b want 0", bus.STALL_E);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed_alu();
        drive(1'b1, 5'd3, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd1, 1'b1, 2'b00, 2'b00, 1'b0);
        @(posedge clk); #1;
        checks++;
        if (bus.WA_EM !== 32'd1) begin errors++; $display("FAIL slt: got %h want 1", bus.WA_EM); end
        drive(1'b1, 5'd4, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd1, 1'b1, 2'b00, 2'b00, 1'b0);
        @(posedge clk); #1;
        checks++;
        if (bus.WA_EM !== 32'd0) begin errors++; $display("FAIL sltu: got %h want 0", bus.WA_EM); end
        drive(1'b1, 5'd0, 32'h100, 32'h3, 32'h1234_5678, 5'd0, 1'b0, 2'b01, 2'b00, 1'b0);
        @(posedge clk); #1;
        checks++;
        if ({bus.WA_EM, bus.WD_EM, bus.MISALIGN_EM, bus.MemWrite_EM} !== {32'h103, 32'h7878_7878, 1'b0, 2'b01}) begin
            errors++;
            $display("FAIL store_byte: got wa=%h wd=%h mis=%b mw=%b want wa=103 wd=78787878 mis=0 mw=01",
                     bus.WA_EM, bus.WD_EM, bus.MISALIGN_EM, bus.MemWrite_EM);
        end
        drive(1'b1, 5'd0, 32'h100, 32'h2, 32'd0, 5'd4, 1'b1, 2'b00, 2'b11, 1'b0);
        @(posedge clk); #1;
        checks++;
        if ({bus.MISALIGN_EM, bus.MemRead_EM, bus.RegWrite_EM, bus.VALID_EM} !== {1'b1, 2'b00, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL misalign_word_load: got mis=%b mr=%b rw=%b v=%b want mis=1 mr=00 rw=0 v=1",
                     bus.MISALIGN_EM, bus.MemRead_EM, bus.RegWrite_EM, bus.VALID_EM);
        end
    endtask

    // Back-to-back random single-cycle traffic with bubbles, stores, loads and odd codes.
    task automatic test_random_alu(input int n);
        logic [4:0]  op, rd;
        logic [31:0] a, b, sd;
        logic [1:0]  mw, mr;
        logic        v, rw, lu, stall_obs;
        logic [77:0] exp_v;
        int          kind;
        for (int i = 0; i < n; i++) begin
            v  = ($urandom_range(0, 7) != 0);
            op = 5'($urandom_range(0, 31));
`ifdef EX_MULDIV_EN
            if (op >= 16 && op <= 23) op = op + 5'd8;
`endif
            a  = $urandom();
            b  = ($urandom_range(0, 1) != 0) ? $urandom() : 32'($urandom_range(0, 40));
            sd = $urandom();
            rd = 5'($urandom_range(0, 31));
            rw = 1'($urandom_range(0, 1));
            lu = 1'($urandom_range(0, 1));
            kind = $urandom_range(0, 2);
            mw = (kind == 1) ? 2'($urandom_range(1, 3)) : 2'b00;
            mr = (kind == 2) ? 2'($urandom_range(1, 3)) : 2'b00;
            drive(v, op, a, b, sd, rd, rw, mw, mr, lu);
            exp_v = {1'b0, ref_em(v, op, a, b, sd, rd, rw, mw, mr, lu)};
            #1;
            stall_obs = bus.STALL_E;
            @(posedge clk); #1;
            checks++;
            if ({stall_obs, em_vec()} !== exp_v) begin
                errors++;
                $display("FAIL random_alu[%0d] op=%0d: got %h want %h", i, op, {stall_obs, em_vec()}, exp_v);
            end
        end
    endtask

`ifdef EX_MULDIV_EN
    // Directed corner cases followed by random operands, issued back to back.
    task automatic test_muldiv();
        logic [4:0]  t_op[$];
        logic [31:0] t_a[$], t_b[$], t_exp[$];
        logic [4:0]  op;
        logic [31:0] a, b;
        int          cyc;
        logic        bubble_bad;
        t_op.push_back(5'd20); t_a.push_back(32'h8000_0000); t_b.push_back(32'hFFFF_FFFF); t_exp.push_back(32'h8000_0000);
        t_op.push_back(5'd21); t_a.push_back(32'd7);         t_b.push_back(32'd0);         t_exp.push_back(32'hFFFF_FFFF);
        t_op.push_back(5'd22); t_a.push_back(32'hFFFF_FFF9); t_b.push_back(32'd2);         t_exp.push_back(32'hFFFF_FFFF);
        t_op.push_back(5'd20); t_a.push_back(32'hFFFF_FFFB); t_b.push_back(32'd0);         t_exp.push_back(32'hFFFF_FFFF);
        t_op.push_back(5'd22); t_a.push_back(32'hFFFF_FFFB); t_b.push_back(32'd0);         t_exp.push_back(32'hFFFF_FFFB);
        t_op.push_back(5'd19); t_a.push_back(32'hFFFF_FFFF); t_b.push_back(32'hFFFF_FFFF); t_exp.push_back(32'hFFFF_FFFE);
        t_op.push_back(5'd18); t_a.push_back(32'hFFFF_FFFF); t_b.push_back(32'hFFFF_FFFF); t_exp.push_back(32'hFFFF_FFFF);
        t_op.push_back(5'd17); t_a.push_back(32'h8000_0000); t_b.push_back(32'h8000_0000); t_exp.push_back(32'h4000_0000);
        t_op.push_back(5'd16); t_a.push_back(32'hFFFF_FFFD); t_b.push_back(32'd5);         t_exp.push_back(32'hFFFF_FFF1);
        for (int i = 0; i < 12; i++) begin
            op = 5'($urandom_range(16, 23));
            a  = $urandom();
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom();
            t_op.push_back(op); t_a.push_back(a); t_b.push_back(b); t_exp.push_back(ref_md(op, a, b));
        end
        for (int i = 0; i < t_op.size(); i++) begin
            drive(1'b1, t_op[i], t_a[i], t_b[i], 32'd0, 5'(i + 1), 1'b1, 2'b00, 2'b00, 1'b0);
            #1;
            cyc = 0;
            bubble_bad = 1'b0;
            while (bus.STALL_E === 1'b1 && cyc < 100) begin
                cyc++;
                @(posedge clk); #2;
                if (bus.VALID_EM !== 1'b0) bubble_bad = 1'b1;
            end
            checks++;
            if (cyc != 33) begin
                errors++;
                $display("FAIL md_stall[%0d] op=%0d: got %0d cycles want 33", i, t_op[i], cyc);
            end
            checks++;
            if (bubble_bad) begin
                errors++;
                $display("FAIL md_bubble[%0d]: got VALID_EM=1 during stall want 0", i);
            end
            @(posedge clk); #1;
            checks++;
            if ({bus.VALID_EM, bus.WA_EM, bus.RD_EM, bus.RegWrite_EM} !== {1'b1, t_exp[i], 5'(i + 1), 1'b1}) begin
                errors++;
                $display("FAIL md_result[%0d] op=%0d a=%h b=%h: got v=%b wa=%h rd=%0d rw=%b want wa=%h rd=%0d",
                         i, t_op[i], t_a[i], t_b[i], bus.VALID_EM, bus.WA_EM, bus.RD_EM, bus.RegWrite_EM,
                         t_exp[i], i + 1);
            end
        end
        drive(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 2'b00, 2'b00, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_op();
        int cyc;
        drive(1'b1, 5'd17, 32'hFFFF_FFFD, 32'd5, 32'd0, 5'd7, 1'b1, 2'b00, 2'b00, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (em_vec() !== 77'd0) begin
            errors++;
            $display("FAIL mid_reset_em: got %h want 0", em_vec());
        end
        rst = 1'b0;
        #1;
        cyc = 0;
        while (bus.STALL_E === 1'b1 && cyc < 100) begin
            cyc++;
            @(posedge clk); #2;
        end
        checks++;
        if (cyc != 33) begin
            errors++;
            $display("FAIL mid_reset_restart: got %0d stall cycles want 33", cyc);
        end
        @(posedge clk); #1;
        checks++;
        if ({bus.VALID_EM, bus.WA_EM} !== {1'b1, 32'hFFFF_FFFF}) begin
            errors++;
            $display("FAIL mid_reset_result: got v=%b wa=%h want v=1 wa=ffffffff", bus.VALID_EM, bus.WA_EM);
        end
        drive(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 2'b00, 2'b00, 1'b0);
        @(posedge clk); #1;
    endtask
`else
    // Without the unit, md codes retire at once as valid no-write instructions.
    task automatic test_md_disabled();
        for (int i = 16; i <= 23; i++) begin
            drive(1'b1, 5'(i), $urandom(), $urandom(), 32'd0, 5'd3, 1'b1, 2'b00, 2'b00, 1'b0);
            #1;
            checks++;
            if (bus.STALL_E !== 1'b0) begin
                errors++;
                $display("FAIL md_off_stall op=%0d: got %b want 0", i, bus.STALL_E);
            end
            @(posedge clk); #1;
            checks++;
            if ({bus.VALID_EM, bus.WA_EM, bus.RegWrite_EM} !== {1'b1, 32'd0, 1'b0}) begin
                errors++;
                $display("FAIL md_off_retire op=%0d: got v=%b wa=%h rw=%b want v=1 wa=0 rw=0",
                         i, bus.VALID_EM, bus.WA_EM, bus.RegWrite_EM);
            end
        end
    endtask
`endif

    initial begin
        drive(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 2'b00, 2'b00, 1'b0);
        @(posedge clk); #1;
        test_reset();
        test_directed_alu();
        test_random_alu(300);
`ifdef EX_MULDIV_EN
        test_muldiv();
        test_reset_mid_op();
`else
        test_md_disabled();
`endif
        test_random_alu(50);
        test_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
